// File: rtl/uart_pkg.sv
// Shared constants and types for the serial receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Parity modes for the PARITY parameter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 100 MHz system clock divided by the 31250-baud MIDI line rate
  localparam int CLKS_PER_BIT_31250 = 100_000_000 / 31_250;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_framed_if.sv
// Received-frame bus: held data, error flags and valid/ready handshake.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer holds the frame in the producer.
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 framing_err;
  logic                 parity_err;
  logic                 overrun;

  // Receiver side drives the frame, consumer drives ready
  modport master (
    output data_out, out_valid, framing_err, parity_err, overrun,
    input  out_ready
  );

  modport slave (
    input  data_out, out_valid, framing_err, parity_err, overrun,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial line plus a previous-sample register.
// Latency: SYNC_STAGES cycles from rx pin to o_rx; o_rx_prev one cycle later.
// Backpressure: none, free-running.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_100mhz,
  input  logic reset,
  input  logic i_rx_async,
  output logic o_rx,
  output logic o_rx_prev
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the async line through the chain; idle-high reset so no false edge
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rx      = r_sync[SYNC_STAGES-1];
  assign o_rx_prev = r_prev;

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver with configurable data/parity/stop bits and error flags.
// Latency: out_valid ~SYNC_STAGES + (DATA_BITS+parity+STOP_BITS+0.5)*CLKS_PER_BIT after start edge.
// Backpressure: one held frame; a frame committed while held and not accepted is dropped (overrun).
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_31250,  // >= 4
  parameter int DATA_BITS    = 8,                   // 5..9, LSB first
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,                   // 1 or 2
  parameter int SYNC_STAGES  = 2                    // >= 2
) (
  input  logic                clk_100mhz,
  input  logic                reset,
  input  logic                rx_in,
  uart_rx_framed_if.master    rx_bus,
  output logic                busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // Half-bit point aligns all later samples to the middle of each bit
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY == PARITY_ODD);

  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_stop_idx;
  logic                 r_ferr;
  logic                 r_perr;

  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_out_ferr;
  logic                 r_out_perr;
  logic                 r_overrun;

  logic w_rx;
  logic w_rx_prev;
  logic w_fall;
  logic w_tick;
  logic w_last_stop;
  logic w_par_err;
  logic w_commit;
  logic w_commit_ferr;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .i_rx_async (rx_in),
    .o_rx       (w_rx),
    .o_rx_prev  (w_rx_prev)
  );

  // A start needs a real high-to-low transition; a line stuck low never retriggers
  assign w_fall        = w_rx_prev & ~w_rx;
  assign w_tick        = (r_cnt == CNT_LAST);
  assign w_last_stop   = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
  assign w_par_err     = ((^r_data) ^ w_rx) != PAR_ODD;
  assign w_commit      = (r_state == ST_STOP) && w_tick && w_last_stop;
  assign w_commit_ferr = r_ferr | ~w_rx;

  // Frame FSM: start qualification, bit sampling and per-frame error collection
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_stop_idx <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (w_rx) begin
              // Line back high at mid-start: treat as a glitch
              r_state <= ST_IDLE;
            end else begin
              r_state    <= ST_DATA;
              r_idx      <= '0;
              r_stop_idx <= 1'b0;
              r_ferr     <= 1'b0;
              r_perr     <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            r_cnt         <= '0;
            r_data[r_idx] <= w_rx;
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_perr  <= w_par_err;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_ferr <= 1'b1;
            end
            // Leave at mid-stop so a start edge right after is not missed
            if (w_last_stop) begin
              r_state <= ST_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output holding register: load on commit if free or being drained, else flag overrun
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ferr  <= 1'b0;
      r_out_perr  <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_commit) begin
      if (!r_out_valid || rx_bus.out_ready) begin
        r_out_data  <= r_data;
        r_out_ferr  <= w_commit_ferr;
        r_out_perr  <= r_perr;
        r_out_valid <= 1'b1;
        // The held frame was consumed this cycle, so any earlier loss is reported
        if (r_out_valid) begin
          r_overrun <= 1'b0;
        end
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_out_valid && rx_bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign rx_bus.data_out    = r_out_data;
  assign rx_bus.out_valid   = r_out_valid;
  assign rx_bus.framing_err = r_out_ferr;
  assign rx_bus.parity_err  = r_out_perr;
  assign rx_bus.overrun     = r_overrun;
  assign busy               = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: four configurations at 16 clocks per bit.
// Latency: frames are driven bit-by-bit on the falling clock edge.
// Backpressure: out_ready is driven per instance, including a single-cycle pulse.
module tb_uart_rx_framed;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rx_line = 4'hF;
  logic [3:0] rdy = 4'hF;

  logic [3:0] vld;
  logic [3:0] ferr;
  logic [3:0] perr;
  logic [3:0] ovr;
  logic [3:0] busy;
  logic [8:0] dat [4];

  int n_cmp = 0;
  int n_err = 0;

  // Handshake monitor state
  int         hs_cnt [4];
  int         vld_cyc [4];
  logic [8:0] hs_dat [4];
  logic       hs_ferr [4];
  logic       hs_perr [4];
  int         b_hs [4];
  int         b_vld [4];

  always #5 clk = ~clk;

  uart_rx_framed_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_framed_if #(.DATA_BITS(8)) bus1 ();
  uart_rx_framed_if #(.DATA_BITS(8)) bus2 ();
  uart_rx_framed_if #(.DATA_BITS(9)) bus3 ();

  // 8N1
  uart_rx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2))
    dut0 (.clk_100mhz(clk), .reset(reset), .rx_in(rx_line[0]), .rx_bus(bus0), .busy(busy[0]));
  // 8E1
  uart_rx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2))
    dut1 (.clk_100mhz(clk), .reset(reset), .rx_in(rx_line[1]), .rx_bus(bus1), .busy(busy[1]));
  // 8O1
  uart_rx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2))
    dut2 (.clk_100mhz(clk), .reset(reset), .rx_in(rx_line[2]), .rx_bus(bus2), .busy(busy[2]));
  // 9N2
  uart_rx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2))
    dut3 (.clk_100mhz(clk), .reset(reset), .rx_in(rx_line[3]), .rx_bus(bus3), .busy(busy[3]));

  assign bus0.out_ready = rdy[0];
  assign bus1.out_ready = rdy[1];
  assign bus2.out_ready = rdy[2];
  assign bus3.out_ready = rdy[3];

  assign vld  = {bus3.out_valid, bus2.out_valid, bus1.out_valid, bus0.out_valid};
  assign ferr = {bus3.framing_err, bus2.framing_err, bus1.framing_err, bus0.framing_err};
  assign perr = {bus3.parity_err, bus2.parity_err, bus1.parity_err, bus0.parity_err};
  assign ovr  = {bus3.overrun, bus2.overrun, bus1.overrun, bus0.overrun};
  assign dat[0] = {1'b0, bus0.data_out};
  assign dat[1] = {1'b0, bus1.data_out};
  assign dat[2] = {1'b0, bus2.data_out};
  assign dat[3] = bus3.data_out;

  // Record every accepted frame and every cycle out_valid is high
  always @(posedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (vld[u]) vld_cyc[u] <= vld_cyc[u] + 1;
      if (vld[u] && rdy[u]) begin
        hs_cnt[u]  <= hs_cnt[u] + 1;
        hs_dat[u]  <= dat[u];
        hs_ferr[u] <= ferr[u];
        hs_perr[u] <= perr[u];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int u);
    b_hs[u]  = hs_cnt[u];
    b_vld[u] = vld_cyc[u];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; optionally raise out_ready only in the commit cycle
  task automatic send_frame(input int u, input logic [8:0] val, input int nd, input int par_bit,
                            input int nstop, input logic stop_val, input bit pulse_rdy);
    logic seq [16];
    int   n;
    n = 0;
    seq[n] = 1'b0; n++;
    for (int i = 0; i < nd; i++) begin seq[n] = val[i]; n++; end
    if (par_bit >= 0) begin seq[n] = par_bit[0]; n++; end
    for (int s = 0; s < nstop; s++) begin seq[n] = stop_val; n++; end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        rx_line[u] = seq[b];
        if (pulse_rdy && b == n - 1 && c == 10) rdy[u] = 1'b1;
        if (pulse_rdy && b == n - 1 && c == 11) rdy[u] = 1'b0;
      end
    end
  endtask

  // Exactly one new accepted frame with the given contents
  task automatic chk_rx(input string tag, input int u, input logic [8:0] d,
                        input logic fe, input logic pe);
    chk({tag, ".count"}, 32'(hs_cnt[u] - b_hs[u]), 32'd1);
    chk({tag, ".data"},  32'(hs_dat[u]), 32'(d));
    chk({tag, ".ferr"},  32'(hs_ferr[u]), 32'(fe));
    chk({tag, ".perr"},  32'(hs_perr[u]), 32'(pe));
  endtask

  // Drive start plus three data bits and half of bit 3, then reset
  task automatic abort_frame(input int u, input logic [8:0] val, input string tag);
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        rx_line[u] = (b == 0) ? 1'b0 : val[b-1];
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rx_line[u] = val[3];
    end
    @(negedge clk);
    chk({tag, ".busy_pre"}, 32'(busy[u]), 32'd1);
    reset = 1'b1;
    rx_line[u] = 1'b1;
    @(negedge clk);
    chk({tag, ".data"}, 32'(dat[u]), 32'd0);
    chk({tag, ".valid"}, 32'(vld[u]), 32'd0);
    chk({tag, ".flags"}, 32'({ferr[u], perr[u], ovr[u], busy[u]}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(300);
    chk({tag, ".no_frame"}, 32'(vld_cyc[u] - b_vld[u]), 32'd0);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst.valid", 32'(vld), 32'd0);
    chk("rst.ferr",  32'(ferr), 32'd0);
    chk("rst.perr",  32'(perr), 32'd0);
    chk("rst.ovr",   32'(ovr), 32'd0);
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.data0", 32'(dat[0]), 32'd0);
    chk("rst.data3", 32'(dat[3]), 32'd0);
    reset = 1'b0;
    idle(4);

    // 8N1 basic frame, consumer always ready
    snap(0);
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, 1'b0);
    idle(4);
    chk_rx("a5", 0, 9'h0A5, 1'b0, 1'b0);
    chk("a5.vld_cycles", 32'(vld_cyc[0] - b_vld[0]), 32'd1);
    chk("a5.ovr", 32'(ovr[0]), 32'd0);

    // Parity: even with wrong bit, even with right bit, odd with right bit
    snap(1);
    send_frame(1, 9'h003, 8, 1, 1, 1'b1, 1'b0);
    idle(4);
    chk_rx("even_bad", 1, 9'h003, 1'b0, 1'b1);
    snap(1);
    send_frame(1, 9'h003, 8, 0, 1, 1'b1, 1'b0);
    idle(4);
    chk_rx("even_ok", 1, 9'h003, 1'b0, 1'b0);
    snap(2);
    send_frame(2, 9'h003, 8, 1, 1, 1'b1, 1'b0);
    idle(4);
    chk_rx("odd_ok", 2, 9'h003, 1'b0, 1'b0);

    // False start: 5-cycle low pulse is rejected at mid-start
    snap(0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rx_line[0] = 1'b0;
    end
    @(negedge clk);
    rx_line[0] = 1'b1;
    chk("glitch.busy_hi", 32'(busy[0]), 32'd1);
    idle(8);
    chk("glitch.busy_lo", 32'(busy[0]), 32'd0);
    idle(40);
    chk("glitch.no_vld", 32'(vld_cyc[0] - b_vld[0]), 32'd0);
    snap(0);
    send_frame(0, 9'h03C, 8, -1, 1, 1'b1, 1'b0);
    idle(4);
    chk_rx("after_glitch", 0, 9'h03C, 1'b0, 1'b0);

    // Bad stop bit, then a break after a one-bit high gap
    snap(0);
    send_frame(0, 9'h081, 8, -1, 1, 1'b0, 1'b0);
    idle(2);
    chk_rx("badstop", 0, 9'h081, 1'b1, 1'b0);
    rx_line[0] = 1'b1;
    idle(16);
    snap(0);
    rx_line[0] = 1'b0;
    idle(40 * 16);
    chk_rx("break", 0, 9'h000, 1'b1, 1'b0);
    chk("break.idle", 32'(busy[0]), 32'd0);
    rx_line[0] = 1'b1;
    idle(32);
    snap(0);
    send_frame(0, 9'h055, 8, -1, 1, 1'b1, 1'b0);
    idle(4);
    chk_rx("after_break", 0, 9'h055, 1'b0, 1'b0);

    // Overrun: hold the first frame, drop the second
    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 8, -1, 1, 1'b1, 1'b0);
    idle(4);
    chk("ovr.first_vld", 32'(vld[0]), 32'd1);
    chk("ovr.first_dat", 32'(dat[0]), 32'h11);
    chk("ovr.first_ovr", 32'(ovr[0]), 32'd0);
    send_frame(0, 9'h022, 8, -1, 1, 1'b1, 1'b0);
    idle(4);
    chk("ovr.held_dat", 32'(dat[0]), 32'h11);
    chk("ovr.set", 32'(ovr[0]), 32'd1);
    chk("ovr.held_vld", 32'(vld[0]), 32'd1);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    chk("ovr.drain_vld", 32'(vld[0]), 32'd0);
    chk("ovr.clear", 32'(ovr[0]), 32'd0);
    chk("ovr.drain_dat", 32'(hs_dat[0]), 32'h11);
    send_frame(0, 9'h044, 8, -1, 1, 1'b1, 1'b0);
    idle(4);
    chk("repl.held_dat", 32'(dat[0]), 32'h44);
    // Ready only in the commit cycle: 0x44 drains and 0x33 takes its place
    send_frame(0, 9'h033, 8, -1, 1, 1'b1, 1'b1);
    idle(2);
    chk("repl.dat", 32'(dat[0]), 32'h33);
    chk("repl.vld", 32'(vld[0]), 32'd1);
    chk("repl.ovr", 32'(ovr[0]), 32'd0);
    chk("repl.drained", 32'(hs_dat[0]), 32'h44);
    rdy[0] = 1'b1;
    idle(4);
    chk("repl.final_vld", 32'(vld[0]), 32'd0);

    // Reset mid-frame on 8N1, then a clean frame
    snap(0);
    abort_frame(0, 9'h00F, "rst8");
    snap(0);
    send_frame(0, 9'h05A, 8, -1, 1, 1'b1, 1'b0);
    idle(4);
    chk_rx("post_rst8", 0, 9'h05A, 1'b0, 1'b0);

    // Same on the 9-bit, two-stop-bit receiver
    snap(3);
    abort_frame(3, 9'h1A5, "rst9");
    snap(3);
    send_frame(3, 9'h1A5, 9, -1, 2, 1'b1, 1'b0);
    idle(4);
    chk_rx("post_rst9", 3, 9'h1A5, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
